sha3_pad_absorb_buffer: RTL and testbench
=========================================

Name: sha3_pad_absorb_buffer

Overview:
- Upstream feeder of the Keccak-f[1600] permutation stage.
- Accepts the message as a stream of 64-bit words with valid/ready handshake.
- Packs words into rate-sized blocks and applies SHA-3 pad10*1 padding with domain byte 0x06.
- Presents each completed block, with a last-block flag, to the permutation stage for XOR absorption.

Parameters:
- R_BLOCK_SIZE, 1088, rate in bits. Must be a multiple of 64. 1088 gives SHA3-256 (17 words); 576, 832 and 1152 are also legal.
- W, 64, input word width in bits. Fixed at 64.

Ports:
- CLK  in  1  clock.
- A_RST  in  1  asynchronous reset, active-high.
- IN_DATA  in  [0:63]  message word. Message byte k of the word is IN_DATA[8k:8k+7]; IN_DATA[8k] is the byte MSB.
- IN_VALID  in  1  IN_DATA, IN_LAST and IN_BYTES are valid.
- IN_READY  out  1  block can accept a word this cycle.
- IN_LAST  in  1  final word of the message.
- IN_BYTES  in  [3:0]  valid bytes in the word, 0..8. Ignored (treated as 8) unless IN_LAST=1.
- BLK  out  [0:R_BLOCK_SIZE-1]  rate block. Message byte i is BLK[8i:8i+7].
- BLK_VALID  out  1  BLK is complete and stable.
- BLK_READY  in  1  permutation stage consumes BLK.
- BLK_LAST  out  1  BLK is the final, padded block of the message.

Behaviour:
- Reset (async, immediate) clears all of the following:
  - buffer to all zeros
  - word index to 0
  - state to FILL
  - BLK_VALID=0, BLK_LAST=0, IN_READY=1
- Input transfer occurs when IN_VALID & IN_READY at a CLK edge.
- Output transfer occurs when BLK_VALID & BLK_READY at a CLK edge.
- States:
  - FILL: IN_READY=1, BLK_VALID=0. Each transfer writes IN_DATA into word slot idx and increments idx.
    - Non-last transfer at idx = R/64-1: go to HOLD with BLK_LAST=0, idx wraps to 0.
    - Last transfer with n=IN_BYTES < 8, or n = 8 with idx < R/64-1:
      - Write the first n bytes.
      - Byte 8*idx+n |= 0x06.
      - Byte R/8-1 |= 0x80.
      - Go to HOLD with BLK_LAST=1.
      - A single-byte overlap gives 0x86 (the n=7 final-slot case).
    - Last transfer with n=8 at idx = R/64-1: go to HOLD with BLK_LAST=0 and set pad_pending.
  - HOLD: IN_READY=0, BLK_VALID=1. BLK, BLK_LAST and BLK_VALID are held stable until BLK_READY.
    - On output transfer, the buffer clears to zero.
    - If pad_pending: load the pad-only block (byte0=0x06, byte R/8-1=0x80, rest 0), set BLK_LAST=1, clear pad_pending, remain in HOLD.
    - Otherwise: return to FILL with idx=0.
- Latency: BLK_VALID rises on the edge that accepts the completing word (registered output, 1 cycle).
- No combinational path from BLK_READY to IN_READY. A word is never accepted in the cycle a block is consumed; this costs one bubble per block.
- Unused bytes of a partial last word are zeroed, not copied.
- Unwritten slots after a last word remain zero.
- IN_BYTES > 8 with IN_LAST is treated as 8.
- IN_LAST with IN_BYTES=0:
  - At idx=0, this is the empty message: block 0x06, 0..0, 0x80, BLK_LAST=1.
  - At idx>0, padding starts at byte 8*idx.
- Reset mid-block or mid-HOLD discards all partial data. No block is emitted.

Optional Feature:
- Macro SHA3_PAD_SHAKE_EN.
- Defined: adds input port DOMAIN_SHAKE (1 bit), sampled with each last-word transfer.
  - DOMAIN_SHAKE=1 uses domain byte 0x1F instead of 0x06, in both in-block and pad-only cases (overlap 0x9F).
  - DOMAIN_SHAKE=0 behaves exactly as undefined.
- Undefined: no port; domain byte is constant 0x06.

Test Plan:
- Empty message (R=1088): IN_LAST=1, IN_BYTES=0 at idx 0 -> one block, byte0=0x06, byte135=0x80, others 0, BLK_LAST=1, BLK_VALID one cycle after accept.
- 3-byte message 0x616263 ("abc"): one word, IN_BYTES=3 -> bytes 0..2=61 62 63, byte3=0x06, byte135=0x80, BLK_LAST=1.
- 135-byte message: 17 words, last IN_BYTES=7 -> single block, byte135=0x86, BLK_LAST=1.
- 136-byte message of 0xAA: 17 full words, last IN_BYTES=8 -> block1 all 0xAA, BLK_LAST=0; then block2 0x06...0x80, BLK_LAST=1. IN_READY=0 throughout both holds.
- Backpressure: hold BLK_READY=0 for 10 cycles after BLK_VALID -> BLK stable, IN_READY=0, no word accepted. Release -> IN_READY=1 next cycle, idx=0.
- Reset mid-fill after 5 words -> BLK_VALID=0, IN_READY=1. A following 3-byte message yields a clean block identical to the "abc" case.

Source files
------------

// File: rtl/sha3_pad_absorb_buffer.sv
// SHA-3 absorb front end: packs 64-bit words into rate blocks with pad10*1.
// Optional SHAKE domain byte select via SHA3_PAD_SHAKE_EN.
module sha3_pad_absorb_buffer #(
  parameter int R_BLOCK_SIZE = 1088,
  parameter int W = 64
) (
  input  logic                    CLK,
  input  logic                    A_RST,
`ifdef SHA3_PAD_SHAKE_EN
  input  logic                    DOMAIN_SHAKE,
`endif
  input  logic [0:W-1]            IN_DATA,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    IN_LAST,
  input  logic [3:0]              IN_BYTES,
  output logic [0:R_BLOCK_SIZE-1] BLK,
  output logic                    BLK_VALID,
  input  logic                    BLK_READY,
  output logic                    BLK_LAST
);

  localparam int NW = R_BLOCK_SIZE / W;
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                  state_q, state_n;
  logic [0:R_BLOCK_SIZE-1] blk_q, blk_n;
  logic [IW-1:0]           idx_q, idx_n;
  logic                    last_q, last_n;
  logic                    pend_q, pend_n;
  logic [7:0]              dom_q, dom_n;
  logic [7:0]              dom;
  logic [3:0]              n;
  int                      base;
  int                      pos;

`ifdef SHA3_PAD_SHAKE_EN
  assign dom = DOMAIN_SHAKE ? 8'h1F : 8'h06;
`else
  assign dom = 8'h06;
`endif

  // Only a last word may be short; oversize counts clamp to a full word.
  assign n = (!IN_LAST || IN_BYTES > 4'd8) ? 4'd8 : IN_BYTES;

  always_comb begin
    state_n = state_q;
    blk_n   = blk_q;
    idx_n   = idx_q;
    last_n  = last_q;
    pend_n  = pend_q;
    dom_n   = dom_q;
    base    = int'(idx_q) * W;
    pos     = int'(idx_q) * 8 + int'(n);
    unique case (state_q)
      FILL: begin
        if (IN_VALID) begin
          for (int j = 0; j < 8; j++) begin
            blk_n[base + 8*j +: 8] =
              (4'(j) < n) ? IN_DATA[8*j +: 8] : 8'h00;
          end
          if (IN_LAST) begin
            dom_n   = dom;
            idx_n   = '0;
            state_n = HOLD;
            if (n != 4'd8 || idx_q != LAST_IDX) begin
              blk_n[pos*8 +: 8] = blk_n[pos*8 +: 8] | dom;
              blk_n[R_BLOCK_SIZE-8 +: 8] =
                blk_n[R_BLOCK_SIZE-8 +: 8] | 8'h80;
              last_n = 1'b1;
            end else begin
              last_n = 1'b0;
              pend_n = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            idx_n   = '0;
            last_n  = 1'b0;
            state_n = HOLD;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (BLK_READY) begin
          blk_n = '0;
          if (pend_q) begin
            // Message filled the rate exactly: emit a pad-only block.
            blk_n[0 +: 8]              = dom_q;
            blk_n[R_BLOCK_SIZE-8 +: 8] = 8'h80;
            last_n = 1'b1;
            pend_n = 1'b0;
          end else begin
            last_n  = 1'b0;
            state_n = FILL;
          end
        end
      end
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge CLK or posedge A_RST) begin
    if (A_RST) begin
      state_q <= FILL;
      blk_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      dom_q   <= 8'h06;
    end else begin
      state_q <= state_n;
      blk_q   <= blk_n;
      idx_q   <= idx_n;
      last_q  <= last_n;
      pend_q  <= pend_n;
      dom_q   <= dom_n;
    end
  end

  assign IN_READY  = (state_q == FILL);
  assign BLK_VALID = (state_q == HOLD);
  assign BLK       = blk_q;
  assign BLK_LAST  = last_q;

endmodule

// File: tb/tb_sha3_pad_absorb_buffer.sv
// Scoreboard bench for sha3_pad_absorb_buffer (R=1088) with a
// byte-level pad10*1 reference model and random backpressure.
module tb_sha3_pad_absorb_buffer;

  localparam int R  = 1088;
  localparam int NB = R / 8;

  logic         CLK = 1'b0;
  logic         A_RST;
  logic [0:63]  IN_DATA;
  logic         IN_VALID;
  logic         IN_READY;
  logic         IN_LAST;
  logic [3:0]   IN_BYTES;
  logic [0:R-1] BLK;
  logic         BLK_VALID;
  logic         BLK_READY;
  logic         BLK_LAST;

  sha3_pad_absorb_buffer #(.R_BLOCK_SIZE(R), .W(64)) dut (
    .CLK(CLK),
    .A_RST(A_RST),
`ifdef SHA3_PAD_SHAKE_EN
    .DOMAIN_SHAKE(1'b0),
`endif
    .IN_DATA(IN_DATA),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .IN_LAST(IN_LAST),
    .IN_BYTES(IN_BYTES),
    .BLK(BLK),
    .BLK_VALID(BLK_VALID),
    .BLK_READY(BLK_READY),
    .BLK_LAST(BLK_LAST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [0:R-1] blk;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           rmode  = 0;
  logic         held   = 1'b0;
  logic [0:R-1] hold_blk;
  logic         hold_last;

  // Reference: append domain byte, zero-fill to a rate multiple, OR 0x80.
  task automatic model(input logic [7:0] m[$]);
    logic [7:0] p[$];
    int L, P;
    exp_t e;
    L = m.size();
    P = ((L + 1 + NB - 1) / NB) * NB;
    p = m;
    p.push_back(8'h06);
    while (p.size() < P) p.push_back(8'h00);
    p[P-1] = p[P-1] | 8'h80;
    for (int b = 0; b < P / NB; b++) begin
      for (int i = 0; i < NB; i++) e.blk[8*i +: 8] = p[b*NB + i];
      e.last = (b == P / NB - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic put_word(input logic [0:63] d, input logic l,
                          input logic [3:0] nb);
    logic r;
    int   t;
    @(negedge CLK);
    IN_DATA  = d;
    IN_LAST  = l;
    IN_BYTES = nb;
    IN_VALID = 1'b1;
    t = 0;
    forever begin
      r = IN_READY;
      @(posedge CLK);
      if (r) break;
      t++;
      if (t > 2000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got no IN_READY want IN_READY=1");
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic send(input logic [7:0] m[$]);
    int L, nw, nb;
    logic [0:63] d;
    logic [3:0] ib;
    L  = m.size();
    nw = (L == 0) ? 1 : (L + 7) / 8;
    model(m);
    for (int w = 0; w < nw; w++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      d = {$urandom, $urandom};
      nb = (w == nw - 1) ? L - 8*w : 8;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = m[8*w + k];
      if (w != nw - 1) ib = 4'($urandom_range(0, 15));
      else if (nb == 8) ib = 4'($urandom_range(8, 15));
      else ib = 4'(nb);
      put_word(d, w == nw - 1, ib);
    end
    checks++;
    if (BLK_VALID !== 1'b1) begin
      errors++;
      $display("FAIL latency BLK_VALID got %b want 1", BLK_VALID);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || BLK_VALID) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    checks++;
    if (t >= 3000) begin
      errors++;
      $display("FAIL drain_timeout pending got %0d want 0", exp_q.size());
    end
  endtask

  task automatic rand_msg(input int L, output logic [7:0] m[$]);
    m = {};
    for (int i = 0; i < L; i++) m.push_back(8'($urandom));
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #2;
      case (rmode)
        1:       BLK_READY = 1'b0;
        2:       BLK_READY = 1'b1;
        default: BLK_READY = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (A_RST) begin
      held = 1'b0;
    end else begin
      checks++;
      if (IN_READY !== !BLK_VALID) begin
        errors++;
        $display("FAIL ready_excl IN_READY got %b want %b",
                 IN_READY, !BLK_VALID);
      end
      if (held) begin
        checks++;
        if (BLK !== hold_blk || BLK_LAST !== hold_last || !BLK_VALID) begin
          errors++;
          $display("FAIL hold_stable got %h/%b want %h/%b",
                   BLK, BLK_LAST, hold_blk, hold_last);
        end
      end
      held = 1'b0;
      if (BLK_VALID && BLK_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_block got %h want none", BLK);
        end else begin
          e = exp_q.pop_front();
          if (BLK !== e.blk || BLK_LAST !== e.last) begin
            errors++;
            $display("FAIL block got %h last %b want %h last %b",
                     BLK, BLK_LAST, e.blk, e.last);
          end
        end
      end else if (BLK_VALID) begin
        held      = 1'b1;
        hold_blk  = BLK;
        hold_last = BLK_LAST;
      end
    end
  end

  initial begin
    logic [7:0] m[$];
    logic [7:0] abc[$];
    abc = '{8'h61, 8'h62, 8'h63};
    IN_DATA = '0; IN_VALID = 1'b0; IN_LAST = 1'b0; IN_BYTES = '0;
    BLK_READY = 1'b0;
    A_RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (BLK_VALID !== 1'b0 || IN_READY !== 1'b1 || BLK_LAST !== 1'b0
        || BLK !== '0) begin
      errors++;
      $display("FAIL reset_state got v%b r%b l%b want v0 r1 l0",
               BLK_VALID, IN_READY, BLK_LAST);
    end
    A_RST = 1'b0;

    m = {};
    send(m);
    send(abc);
    rand_msg(135, m);
    send(m);
    m = {};
    for (int i = 0; i < 136; i++) m.push_back(8'hAA);
    send(m);
    drain();

    rmode = 1;
    send(abc);
    IN_DATA = {$urandom, $urandom};
    IN_LAST = 1'b1; IN_BYTES = 4'd3; IN_VALID = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      checks++;
      if (IN_READY !== 1'b0 || BLK_VALID !== 1'b1) begin
        errors++;
        $display("FAIL backpressure got r%b v%b want r0 v1",
                 IN_READY, BLK_VALID);
      end
    end
    IN_VALID = 1'b0;
    rmode = 2;
    repeat (2) @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1 || BLK_VALID !== 1'b0) begin
      errors++;
      $display("FAIL release got r%b v%b want r1 v0", IN_READY, BLK_VALID);
    end
    rand_msg(200, m);
    send(m);
    drain();
    rmode = 0;

    for (int w = 0; w < 5; w++) put_word({$urandom, $urandom}, 1'b0, 4'd8);
    A_RST = 1'b1;
    #1;
    checks++;
    if (BLK_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got v%b r%b want v0 r1", BLK_VALID, IN_READY);
    end
    @(negedge CLK);
    A_RST = 1'b0;
    send(abc);
    drain();

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 3))
        0:       rand_msg($urandom_range(0, 16), m);
        1:       rand_msg(NB - 1 + $urandom_range(0, 2), m);
        2:       rand_msg(2*NB - 1 + $urandom_range(0, 2), m);
        default: rand_msg($urandom_range(0, 3*NB), m);
      endcase
      send(m);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
